// File: rtl/ddr_nch_apb_mux.sv
// ddr_nch_apb_mux
//   Bridges one upstream APB3 slave port onto NUM_CH downstream DDR-channel
//   APB ports. addr[10:8] picks the channel and addr[7:0] is the register
//   offset. An out-of-range channel gets an immediate error response. A stuck
//   channel is cut off after TIMEOUT_CYC access cycles with an error response.
//   The block also synchronizes the per-channel init-done flags.
//
// Optional feature (macro DDR_APB_BCAST_EN):
//   When defined, a write to select 3'b111 is broadcast to every channel.
//   When undefined, 3'b111 is an ordinary out-of-range select.
//
// Ports
//   apb_clk, apb_rst_n         clock, async active-low reset
//   apb_sel/enable/write       upstream APB3 controls
//   apb_addr[10:0], apb_wdata  upstream address / write data
//   apb_rdata/ready/slverr     upstream response (ready is a 1-cycle pulse)
//   ch_apb_sel/enable[N]       per-channel select / enable
//   ch_apb_write/addr/wdata    shared registered downstream controls
//   ch_apb_rdata[N][16]        per-channel read data
//   ch_apb_ready[N]            per-channel ready
//   ch_init_done[N]            async per-channel init-done flags
//   init_done_vec, all_init_done  synchronized flags and their registered AND

// Two-flop synchronizer for one asynchronous status bit.
module ddr_nch_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

module ddr_nch_apb_mux #(
  parameter int NUM_CH      = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   apb_clk,
  input  logic                   apb_rst_n,
  input  logic                   apb_sel,
  input  logic                   apb_enable,
  input  logic                   apb_write,
  input  logic [10:0]            apb_addr,
  input  logic [15:0]            apb_wdata,
  output logic [15:0]            apb_rdata,
  output logic                   apb_ready,
  output logic                   apb_slverr,
  output logic [NUM_CH-1:0]      ch_apb_sel,
  output logic [NUM_CH-1:0]      ch_apb_enable,
  output logic                   ch_apb_write,
  output logic [7:0]             ch_apb_addr,
  output logic [15:0]            ch_apb_wdata,
  input  logic [NUM_CH-1:0][15:0] ch_apb_rdata,
  input  logic [NUM_CH-1:0]      ch_apb_ready,
  input  logic [NUM_CH-1:0]      ch_init_done,
  output logic [NUM_CH-1:0]      init_done_vec,
  output logic                   all_init_done
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  localparam logic [3:0] NCH     = 4'(NUM_CH);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);
  localparam logic [15:0] ERR_DATA = 16'hDEAD;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [7:0]        addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  // Channels still owing a response; one-hot for unicast, all ones for broadcast.
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              slverr_q, slverr_d;
  logic              all_q;

  logic [NUM_CH-1:0] onehot, left;
  logic [15:0]       rd_sel;
  logic              hit, bcast;

  assign hit = {1'b0, apb_addr[10:8]} < NCH;

`ifdef DDR_APB_BCAST_EN
  assign bcast = (apb_addr[10:8] == 3'b111) && apb_write;
`else
  assign bcast = 1'b0;
`endif

  // Channels that have not yet answered this cycle; ready from channels
  // outside the pending set never counts.
  assign left = pend_q & ~ch_apb_ready;

  always_comb begin
    onehot = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      onehot[i] = (apb_addr[10:8] == 3'(i));
      if (pend_q[i]) rd_sel = rd_sel | ch_apb_rdata[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    unique case (state_q)
      S_IDLE: begin
        if (apb_sel && !apb_enable) begin
          write_d  = apb_write;
          addr_d   = apb_addr[7:0];
          wdata_d  = apb_wdata;
          cnt_d    = '0;
          rdata_d  = '0;
          slverr_d = 1'b0;
          if (bcast) begin
            pend_d  = '1;
            state_d = S_SETUP;
          end else if (hit) begin
            pend_d  = onehot;
            state_d = S_SETUP;
          end else begin
            pend_d   = '0;
            rdata_d  = ERR_DATA;
            slverr_d = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        cnt_d  = cnt_q + 10'd1;
        pend_d = left;
        if (left == '0) begin
          state_d = S_RESP;
          if (!write_q) rdata_d = rd_sel;
        end else if (cnt_q == TO_LAST) begin
          state_d  = S_RESP;
          pend_d   = '0;
          rdata_d  = ERR_DATA;
          slverr_d = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      all_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      all_q    <= &init_done_vec;
    end
  end

  ddr_nch_sync2 u_sync [NUM_CH-1:0] (
    .clk   (apb_clk),
    .rst_n (apb_rst_n),
    .d_i   (ch_init_done),
    .q_o   (init_done_vec)
  );

  assign ch_apb_sel    = (state_q == S_SETUP || state_q == S_ACCESS) ? pend_q : '0;
  assign ch_apb_enable = (state_q == S_ACCESS) ? pend_q : '0;
  assign ch_apb_write  = write_q;
  assign ch_apb_addr   = addr_q;
  assign ch_apb_wdata  = wdata_q;
  assign apb_ready     = (state_q == S_RESP);
  assign apb_rdata     = rdata_q;
  assign apb_slverr    = slverr_q;
  assign all_init_done = all_q;

endmodule

// File: doc/ddr_nch_apb_mux.md
DDR_NCH_APB_MUX -- requirements
Module: ddr_nch_apb_mux

Interface
REQ-001 Parameter NUM_CH, default 3, number of DDR channels served, legal 1..7.
REQ-002 Parameter TIMEOUT_CYC, default 255, maximum ACCESS-state cycles before error response, legal 1..1023.
REQ-003 apb_clk  input  1  sole clock; all logic on rising edge.
REQ-004 apb_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 apb_sel / apb_enable / apb_write  input  1 each  upstream APB3 slave controls.
REQ-006 apb_addr  input  11  [10:8] channel select, [7:0] register offset.
REQ-007 apb_wdata  input  16  upstream write data.
REQ-008 apb_rdata / apb_ready / apb_slverr  output  16/1/1  upstream response.
REQ-009 ch_apb_sel / ch_apb_enable  output  NUM_CH each  per-channel select/enable.
REQ-010 ch_apb_write / ch_apb_addr / ch_apb_wdata  output  1/8/16  shared, registered downstream controls.
REQ-011 ch_apb_rdata  input  16*NUM_CH  channel n occupies [16n+15:16n].
REQ-012 ch_apb_ready  input  NUM_CH  per-channel ready.
REQ-013 ch_init_done  input  NUM_CH  per-channel init done, asynchronous to apb_clk.
REQ-014 init_done_vec / all_init_done  output  NUM_CH/1  synchronized status and its AND.

Function
REQ-015 FSM states IDLE, SETUP, ACCESS, RESP; only IDLE accepts a new transfer.
REQ-016 IDLE: apb_sel=1 and apb_enable=0 registers write/addr[7:0]/wdata and decodes addr[10:8]; target < NUM_CH -> SETUP, otherwise -> RESP with apb_slverr=1.
REQ-017 SETUP lasts exactly one cycle: target ch_apb_sel=1, ch_apb_enable=0; then ACCESS.
REQ-018 ACCESS: target ch_apb_sel=1 and ch_apb_enable=1 until its ch_apb_ready sampled high; then capture its rdata slice, -> RESP, deassert sel/enable.
REQ-019 RESP lasts exactly one cycle: apb_ready=1, apb_rdata and apb_slverr valid; then IDLE; apb_ready is 0 in all other states.
REQ-020 Latency: setup cycle T0 with downstream ready in first ACCESS cycle -> apb_ready high in T0+3.
REQ-021 Timeout counter (10 bits) clears on SETUP entry, increments each ACCESS cycle; reaching TIMEOUT_CYC without completion -> RESP, apb_slverr=1, apb_rdata=16'hDEAD, downstream sel/enable dropped.
REQ-022 Error responses from decode carry apb_rdata=16'hDEAD; successful writes return apb_rdata=0, apb_slverr=0.
REQ-023 ch_apb_ready on non-targeted channels and during non-ACCESS states is ignored.
REQ-024 Each ch_init_done bit passes a two-flop synchronizer into init_done_vec; all_init_done is a registered AND of init_done_vec (three-cycle worst-case latency).
REQ-025 Upstream protocol violations (apb_sel dropped mid-transfer) do not abort the FSM; the transfer completes and the RESP pulse is still issued.

Reset
REQ-026 apb_rst_n low forces IDLE immediately, including mid-transfer; all outputs 0, synchronizer flops 0, timeout counter 0.
REQ-027 After reset release, first transfer is accepted on the first rising edge with apb_rst_n high.

Configuration
REQ-028 Macro DDR_APB_BCAST_EN defined: addr[10:8]=3'b111 with apb_write=1 is a broadcast write to all NUM_CH channels; each channel's sel/enable drop individually on its ready; RESP once all have responded; timeout sets apb_slverr=1; broadcast read -> decode error.
REQ-029 Macro DDR_APB_BCAST_EN undefined: 3'b111 is an out-of-range select handled per REQ-016; no broadcast logic is synthesized.

Verification
REQ-030 Write addr 11'h105, wdata 16'h1234, ch1 ready in first ACCESS cycle -> ch_apb_sel=3'b010, ch_apb_addr=8'h05, apb_ready at T0+3, apb_slverr=0.
REQ-031 Read addr 11'h210, ch2 rdata 16'hA5A5, ready after 4 ACCESS cycles -> apb_rdata=16'hA5A5, apb_ready at T0+6.
REQ-032 Read addr 11'h310 with NUM_CH=3 -> no ch_apb_sel activity, apb_ready at T0+1, apb_slverr=1, apb_rdata=16'hDEAD.
REQ-033 Write to ch0, ch_apb_ready held 0, TIMEOUT_CYC=8 -> apb_ready after 8 ACCESS cycles, apb_slverr=1, apb_rdata=16'hDEAD.
REQ-034 DDR_APB_BCAST_EN defined, write addr 11'h720, readies at ACCESS cycles 1/3/2 for ch0/ch1/ch2 -> RESP after cycle 3, apb_slverr=0; undefined -> decode error.
REQ-035 apb_rst_n pulsed low during ACCESS -> all outputs 0 same cycle; ch_init_done=3'b111 after release -> all_init_done=1 within 3 cycles.
